// File: rtl/robot_mission_ctrl_if.sv
// Signal bundle between the mission host / robot core and the mission controller.
// cleared_valid is a one-cycle strobe with no ready (cleared_row/col valid only while it is high); start is sampled only while busy is low.
interface robot_mission_ctrl_if #(
    parameter int MOVE_W  = 9,
    parameter int TRASH_W = 8
);
    logic               start;
    logic [3:0]         init_row;
    logic [4:0]         init_col;
    logic [1:0]         init_orient;
    logic [MOVE_W-1:0]  max_moves;
    logic               front;
    logic               turn;
    logic               remove;
    logic               robot_en;
    logic [3:0]         row;
    logic [4:0]         column;
    logic [1:0]         orient;
    logic [MOVE_W-1:0]  steps;
    logic [TRASH_W-1:0] trash_count;
    logic               cleared_valid;
    logic [3:0]         cleared_row;
    logic [4:0]         cleared_col;
    logic               busy;
    logic               done;
    logic [2:0]         status;
    logic [1:0]         fsm_state;

    modport master (
        output start, init_row, init_col, init_orient, max_moves, front, turn, remove,
        input  robot_en, row, column, orient, steps, trash_count, cleared_valid,
               cleared_row, cleared_col, busy, done, status, fsm_state
    );

    modport slave (
        input  start, init_row, init_col, init_orient, max_moves, front, turn, remove,
        output robot_en, row, column, orient, steps, trash_count, cleared_valid,
               cleared_row, cleared_col, busy, done, status, fsm_state
    );
endinterface

// File: rtl/robot_mission_ctrl.sv
// Mission sequencer for the pipe-cleaning robot: loads the start pose, enables the core,
// tracks odometry and trash removal, and ends the run on budget, closed loop or fault.
module robot_mission_ctrl #(
    parameter int MAX_ROW       = 10,
    parameter int MAX_COL       = 20,
    parameter int MOVE_W        = 9,
    parameter int TRASH_W       = 8,
    parameter int REMOVE_CYCLES = 3,
    parameter int STALL_LIMIT   = 8
) (
    input  logic clock,
    input  logic reset,
    robot_mission_ctrl_if.slave bus
);
    localparam int RW = $clog2(REMOVE_CYCLES + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [3:0]    ROW_MAX    = 4'(MAX_ROW);
    localparam logic [4:0]    COL_MAX    = 5'(MAX_COL);
    localparam logic [RW-1:0] REM_LAST   = RW'(REMOVE_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    localparam logic [1:0] NORTH = 2'b00, SOUTH = 2'b01, EAST = 2'b10, WEST = 2'b11;
    localparam logic [2:0] ST_NONE = 3'b000, ST_BUDGET = 3'b001, ST_LOOP = 3'b010,
                           ST_OOM = 3'b100, ST_ILLEGAL = 3'b101, ST_STALL = 3'b110,
                           ST_ABORT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d, start_row_q, start_row_d, fwd_row, clr_row_q, clr_row_d;
    logic [4:0]         col_q, col_d, start_col_q, start_col_d, fwd_col, clr_col_q, clr_col_d;
    logic [1:0]         orient_q, orient_d, start_orient_q, start_orient_d;
    logic [MOVE_W-1:0]  steps_q, steps_d, budget_q, budget_d;
    logic [TRASH_W-1:0] trash_q, trash_d;
    logic [2:0]         status_q, status_d, fault_code;
    logic [RW-1:0]      rem_q, rem_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic               moved_q, moved_d, clr_valid_q, clr_valid_d;
    logic               act, illegal, fault, fwd_ok, start_bad;

    function automatic logic [1:0] turn_left(input logic [1:0] o);
        case (o)
            NORTH:   return WEST;
            WEST:    return SOUTH;
            SOUTH:   return EAST;
            default: return NORTH;
        endcase
    endfunction

    // Cell ahead of the current pose; used both for moves and for the cleared-cell report.
    always_comb begin
        fwd_row = row_q;
        fwd_col = col_q;
        case (orient_q)
            NORTH:   fwd_row = row_q - 4'd1;
            SOUTH:   fwd_row = row_q + 4'd1;
            EAST:    fwd_col = col_q + 5'd1;
            default: fwd_col = col_q - 5'd1;
        endcase
    end

    assign fwd_ok = (fwd_row >= 4'd1) && (fwd_row <= ROW_MAX) &&
                    (fwd_col >= 5'd1) && (fwd_col <= COL_MAX);
    assign start_bad = (bus.init_row == 4'd0) || (bus.init_row > ROW_MAX) ||
                       (bus.init_col == 5'd0) || (bus.init_col > COL_MAX);
    assign act     = bus.front | bus.turn | bus.remove;
    assign illegal = (bus.front & bus.turn) | (bus.front & bus.remove) | (bus.turn & bus.remove);

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        orient_d       = orient_q;
        start_row_d    = start_row_q;
        start_col_d    = start_col_q;
        start_orient_d = start_orient_q;
        budget_d       = budget_q;
        steps_d        = steps_q;
        trash_d        = trash_q;
        status_d       = status_q;
        rem_d          = rem_q;
        stall_d        = stall_q;
        moved_d        = moved_q;
        clr_valid_d    = 1'b0;
        clr_row_d      = clr_row_q;
        clr_col_d      = clr_col_q;
        fault          = 1'b0;
        fault_code     = ST_NONE;
        case (state_q)
            S_RUN: begin
                steps_d = steps_q + MOVE_W'(1);
                if (illegal) begin
                    fault = 1'b1; fault_code = ST_ILLEGAL;
                end else if (bus.front && !fwd_ok) begin
                    fault = 1'b1; fault_code = ST_OOM;
                end else if ((rem_q != '0) && !bus.remove) begin
                    fault = 1'b1; fault_code = ST_ABORT;
                end else if (!act && (stall_q == STALL_LAST)) begin
                    fault = 1'b1; fault_code = ST_STALL;
                end
                if (fault) begin
                    state_d  = S_FAULT;
                    status_d = fault_code;
                end else begin
                    if (bus.front) begin
                        row_d   = fwd_row;
                        col_d   = fwd_col;
                        moved_d = 1'b1;
                    end
                    if (bus.turn) orient_d = turn_left(orient_q);
                    if (bus.remove) begin
                        if (rem_q == REM_LAST) begin
                            rem_d       = '0;
                            clr_valid_d = 1'b1;
                            clr_row_d   = fwd_row;
                            clr_col_d   = fwd_col;
                            if (trash_q != '1) trash_d = trash_q + TRASH_W'(1);
                        end else begin
                            rem_d = rem_q + RW'(1);
                        end
                    end
                    stall_d = act ? '0 : stall_q + SW'(1);
                    // A closed loop takes precedence over an exhausted budget in the same cycle.
                    if (moved_d && (row_d == start_row_q) && (col_d == start_col_q) &&
                        (orient_d == start_orient_q)) begin
                        state_d  = S_DONE;
                        status_d = ST_LOOP;
                    end else if (steps_d == budget_q) begin
                        state_d  = S_DONE;
                        status_d = ST_BUDGET;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    row_d          = bus.init_row;
                    col_d          = bus.init_col;
                    orient_d       = bus.init_orient;
                    start_row_d    = bus.init_row;
                    start_col_d    = bus.init_col;
                    start_orient_d = bus.init_orient;
                    budget_d       = bus.max_moves;
                    steps_d        = '0;
                    trash_d        = '0;
                    status_d       = ST_NONE;
                    rem_d          = '0;
                    stall_d        = '0;
                    moved_d        = 1'b0;
                    if (start_bad) begin
                        state_d  = S_FAULT;
                        status_d = ST_OOM;
                    end else if (bus.max_moves == '0) begin
                        state_d  = S_DONE;
                        status_d = ST_BUDGET;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            row_q          <= 4'd1;
            col_q          <= 5'd1;
            orient_q       <= NORTH;
            start_row_q    <= '0;
            start_col_q    <= '0;
            start_orient_q <= '0;
            budget_q       <= '0;
            steps_q        <= '0;
            trash_q        <= '0;
            status_q       <= ST_NONE;
            rem_q          <= '0;
            stall_q        <= '0;
            moved_q        <= 1'b0;
            clr_valid_q    <= 1'b0;
            clr_row_q      <= '0;
            clr_col_q      <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            orient_q       <= orient_d;
            start_row_q    <= start_row_d;
            start_col_q    <= start_col_d;
            start_orient_q <= start_orient_d;
            budget_q       <= budget_d;
            steps_q        <= steps_d;
            trash_q        <= trash_d;
            status_q       <= status_d;
            rem_q          <= rem_d;
            stall_q        <= stall_d;
            moved_q        <= moved_d;
            clr_valid_q    <= clr_valid_d;
            clr_row_q      <= clr_row_d;
            clr_col_q      <= clr_col_d;
        end
    end

    assign bus.robot_en      = (state_q == S_RUN);
    assign bus.busy          = (state_q == S_RUN);
    assign bus.done          = (state_q == S_DONE) || (state_q == S_FAULT);
    assign bus.row           = row_q;
    assign bus.column        = col_q;
    assign bus.orient        = orient_q;
    assign bus.steps         = steps_q;
    assign bus.trash_count   = trash_q;
    assign bus.status        = status_q;
    assign bus.cleared_valid = clr_valid_q;
    assign bus.cleared_row   = clr_row_q;
    assign bus.cleared_col   = clr_col_q;
    assign bus.fsm_state     = state_q;
endmodule
